// File: rtl/snake_score_manager_if.sv
`default_nettype none
// ============================================================================
//  Module      : snake_score_manager_if
//  Description : Collision/control inputs and score/status outputs of the
//                snake score manager, grouped as one bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snake_score_manager_if #(
  parameter int SCORE_W = 7,
  parameter int LIFE_W  = 2
);
  logic               start;
  logic               goodColl;
  logic               badColl;
  logic               clearHigh;
  logic [SCORE_W-1:0] currScore;
  logic [SCORE_W-1:0] highScore;
  logic [LIFE_W-1:0]  livesLeft;
  logic               playing;
  logic               isGameComplete;
  logic               won;
  logic               newHigh;

  // Game controller / collision detector side
  modport master (
    output start, goodColl, badColl, clearHigh,
    input  currScore, highScore, livesLeft, playing, isGameComplete, won, newHigh
  );

  // Score manager side
  modport slave (
    input  start, goodColl, badColl, clearHigh,
    output currScore, highScore, livesLeft, playing, isGameComplete, won, newHigh
  );
endinterface
`default_nettype wire

// File: rtl/snake_score_manager.sv
`default_nettype none
// ============================================================================
//  Module      : snake_score_manager
//  Description : Score, lives and session high-score tracker with an
//                IDLE / PLAY / OVER game-level state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_score_manager #(
  parameter int SCORE_W   = 7,
  parameter int MAX_SCORE = 100,
  parameter int GOOD_PTS  = 1,
  parameter int NUM_LIVES = 3,
  parameter int LIFE_W    = 2
) (
  input  wire                  clk,
  input  wire                  nRst,
  snake_score_manager_if.slave bus
);

  localparam logic [SCORE_W-1:0] C_MAX_SCORE = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W:0]   C_MAX_WIDE  = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [SCORE_W:0]   C_GOOD_PTS  = (SCORE_W+1)'(GOOD_PTS);
  localparam logic [LIFE_W-1:0]  C_LIVES     = LIFE_W'(NUM_LIVES);
  localparam logic [LIFE_W-1:0]  C_ONE_LIFE  = LIFE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic               won_q, won_d;
  logic               new_high_q, new_high_d;
  logic               playing_q, playing_d;
  logic               complete_q, complete_d;
  logic               win_now;
  logic [SCORE_W:0]   sum_wide;

  // One extra bit so the saturation test cannot be fooled by wrap-around.
  assign sum_wide = {1'b0, score_q} + C_GOOD_PTS;

  // Next-state logic: score first, then high score, then life loss unless the
  // same edge produced a win.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    lives_d    = lives_q;
    won_d      = won_q;
    new_high_d = new_high_q;
    win_now    = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (bus.goodColl) begin
          if (sum_wide >= C_MAX_WIDE) begin
            score_d = C_MAX_SCORE;
            won_d   = 1'b1;
            state_d = ST_OVER;
            win_now = 1'b1;
          end else begin
            score_d = sum_wide[SCORE_W-1:0];
          end
        end
        if (score_d > high_q) begin
          high_d     = score_d;
          new_high_d = 1'b1;
        end
        if (bus.badColl && !win_now && (lives_q != '0)) begin
          lives_d = lives_q - C_ONE_LIFE;
          if (lives_q == C_ONE_LIFE) begin
            state_d = ST_OVER;
          end
        end
      end
      default: begin
        // IDLE and OVER: collisions ignored, results held until a new start.
        if (bus.clearHigh) begin
          high_d = '0;
        end
        if (bus.start) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          lives_d    = C_LIVES;
          won_d      = 1'b0;
          new_high_d = 1'b0;
        end
      end
    endcase

    playing_d  = (state_d == ST_PLAY);
    complete_d = (state_d == ST_OVER);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      lives_q    <= C_LIVES;
      won_q      <= 1'b0;
      new_high_q <= 1'b0;
      playing_q  <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      lives_q    <= lives_d;
      won_q      <= won_d;
      new_high_q <= new_high_d;
      playing_q  <= playing_d;
      complete_q <= complete_d;
    end
  end

  assign bus.currScore      = score_q;
  assign bus.highScore      = high_q;
  assign bus.livesLeft      = lives_q;
  assign bus.playing        = playing_q;
  assign bus.isGameComplete = complete_q;
  assign bus.won            = won_q;
  assign bus.newHigh        = new_high_q;

endmodule
`default_nettype wire

// File: doc/snake_score_manager.md
Name: snake_score_manager

Overview:
- Parametrised score/lives tracker for the snake game: counts points on good collisions, tracks lives, keeps a session high score and runs a game-level state machine (idle, playing, over).
- Sits between the collision detector (goodColl/badColl pulses) and the display/game controller.
- Adds to the earlier single-life tracker: configurable score width and limits, multi-life play, win/lose distinction, explicit start, and high-score clear.

Parameters:
- SCORE_W, 7, width of the score registers.
- MAX_SCORE, 100, winning score; must be < 2**SCORE_W.
- GOOD_PTS, 1, points added per goodColl; must be ≥ 1 and ≤ MAX_SCORE.
- NUM_LIVES, 3, lives per game; must be ≥ 1.
- LIFE_W, 2, width of the lives counter; NUM_LIVES must be < 2**LIFE_W.

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous active-low reset.
- start  input  1  begin a new game (sampled level, acted on in IDLE/OVER).
- goodColl  input  1  food eaten this cycle.
- badColl  input  1  wall/self collision this cycle.
- clearHigh  input  1  zero the high score (IDLE/OVER only).
- currScore  output  SCORE_W  current game score.
- highScore  output  SCORE_W  best score since reset/clear.
- livesLeft  output  LIFE_W  remaining lives.
- playing  output  1  high in PLAY.
- isGameComplete  output  1  high in OVER.
- won  output  1  high in OVER when the game ended by reaching MAX_SCORE.
- newHigh  output  1  sticky: the current/last game set a new high score.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, nRst). All outputs are registered; outputs are decoded from registered state.
- Reset state: IDLE, currScore=0, highScore=0, livesLeft=NUM_LIVES, won=0, newHigh=0. This gives playing=0 and isGameComplete=0.
- Reset mid-game returns immediately to the reset state and discards the high score.
- Inputs take effect on the next rising edge (1-cycle latency).
- IDLE:
  - goodColl/badColl are ignored.
  - start → PLAY, with currScore=0, livesLeft=NUM_LIVES, won=0, newHigh=0.
  - clearHigh → highScore=0.
  - start and clearHigh together: both apply.
- PLAY:
  - goodColl: sum = currScore + GOOD_PTS, computed at SCORE_W+1 bits.
    - If sum ≥ MAX_SCORE: currScore=MAX_SCORE, won=1, go to OVER.
    - Otherwise currScore=sum.
  - High score: if the new currScore > highScore, highScore takes the new currScore on the same edge and newHigh=1. The comparison is unsigned.
  - badColl: livesLeft decrements.
    - If livesLeft was 1: livesLeft=0, go to OVER with won=0.
    - Score is kept; it does not reset.
  - goodColl and badColl in the same cycle: the score update and high-score update apply first, then the life is lost.
    - If the score reaches MAX_SCORE on that edge, the win takes priority: livesLeft is not decremented and won=1.
  - start and clearHigh are ignored in PLAY.
- OVER:
  - currScore, livesLeft, won and newHigh hold their values.
  - goodColl/badColl are ignored.
  - clearHigh → highScore=0; newHigh is unaffected.
  - start → PLAY with the same initialisation as from IDLE. The high score is retained unless clearHigh is asserted in the same cycle.
- No state wraps: score saturates at MAX_SCORE, and lives never go below 0.

Test Plan:
- Reset, then start=1 for one cycle → next cycle: playing=1, livesLeft=3, currScore=0.
- PLAY, 5 goodColl pulses → currScore=5, highScore=5, newHigh=1. Then 3 badColl → after the 3rd: isGameComplete=1, won=0, livesLeft=0, currScore=5.
- From OVER, start, then 2 goodColl → currScore=2, highScore stays 5, newHigh=0. Then 4 more goodColl → at score 6, highScore=6 and newHigh=1 on the same edge.
- With MAX_SCORE=100, GOOD_PTS=3: 34 goodColl → currScore=100 (saturated from 99+3), won=1, isGameComplete=1. Further goodColl leaves the score at 100.
- goodColl and badColl together at livesLeft=1, score 50 → currScore=51, highScore updated if exceeded, livesLeft=0, OVER, won=0. Repeat with score at MAX_SCORE-1 → won=1, livesLeft stays 1.
- clearHigh in PLAY → highScore unchanged. clearHigh in OVER → highScore=0. Assert nRst mid-game → all outputs return to reset values asynchronously, before the next clock edge.
